// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: word length, parity, stop bits, 3-sample majority vote,
// parity/framing/break flags. Delivers each word with a one-cycle o_DV strobe.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic                 i_SERIAL,
  output logic                 o_DV,
  output logic [DATA_BITS-1:0] o_BYTE,
  output logic                 o_PARITY_ERR,
  output logic                 o_FRAME_ERR,
  output logic                 o_BREAK,
  output logic                 o_BUSY
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W   = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF    = (CLKS_PER_BIT - 1) / 2;
  localparam bit          HAS_PAR = (PARITY != 0);
  localparam bit          ODD_PAR = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [2:0]           hist_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 wait_high_q, wait_high_d;
  logic                 dv_d, perr_o_d, ferr_o_d, brk_d, busy_d;
  logic [DATA_BITS-1:0] byte_d;

  logic line_s, maj, bit_tick, half_tick, last_data, last_stop, ferr_now;

  assign line_s    = sync_q[1];
  assign maj       = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign bit_tick  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half_tick = (cnt_q == CNT_W'(HALF));
  assign last_data = (idx_q == IDX_W'(DATA_BITS - 1));
  assign last_stop = (idx_q == IDX_W'(STOP_BITS - 1));
  assign ferr_now  = ferr_q | ~maj;

  // State register
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!line_s && !wait_high_q) state_d = S_START;
      S_START:  if (half_tick) state_d = maj ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_tick && last_data) begin
          if (HAS_PAR) state_d = S_PARITY;
          else         state_d = S_STOP;
        end
      end
      S_PARITY: if (bit_tick) state_d = S_STOP;
      S_STOP:   if (bit_tick && last_stop) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    wait_high_d = wait_high_q & ~line_s;
    dv_d        = 1'b0;
    byte_d      = o_BYTE;
    perr_o_d    = o_PARITY_ERR;
    ferr_o_d    = o_FRAME_ERR;
    brk_d       = o_BREAK;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        idx_d     = '0;
        par_bit_d = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
      end
      S_START: if (half_tick) cnt_d = '0;
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          idx_d   = last_data ? '0 : idx_q + IDX_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d     = '0;
          par_bit_d = maj;
          perr_d    = ((^shift_q) ^ maj) != ODD_PAR;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d  = '0;
          ferr_d = ferr_now;
          if (last_stop) begin
            idx_d    = '0;
            dv_d     = 1'b1;
            byte_d   = shift_q;
            perr_o_d = perr_q;
            ferr_o_d = ferr_now;
            brk_d    = (shift_q == '0) && ferr_now && !(HAS_PAR && par_bit_q);
            // A low final stop means the line is still low: no start edge until it rises.
            wait_high_d = ~maj;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  // Synchroniser, sample history, datapath and registered outputs
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      sync_q       <= 2'b11;
      hist_q       <= 3'b111;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      wait_high_q  <= 1'b0;
      o_DV         <= 1'b0;
      o_BYTE       <= '0;
      o_PARITY_ERR <= 1'b0;
      o_FRAME_ERR  <= 1'b0;
      o_BREAK      <= 1'b0;
      o_BUSY       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], i_SERIAL};
      hist_q       <= {hist_q[1:0], line_s};
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      wait_high_q  <= wait_high_d;
      o_DV         <= dv_d;
      o_BYTE       <= byte_d;
      o_PARITY_ERR <= perr_o_d;
      o_FRAME_ERR  <= ferr_o_d;
      o_BREAK      <= brk_d;
      o_BUSY       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances, table-driven frames plus
// hand sequences for glitch, break, back-to-back with spikes and mid-frame reset.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  typedef struct {
    logic [8:0] byte_v;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  typedef struct {
    int         d;
    logic [8:0] data;
    int         nbits;
    logic       par_en;
    logic       par_bit;
    logic [1:0] stop;
    int         nstop;
    logic [8:0] ebyte;
    logic       eperr;
    logic       eferr;
    logic       ebrk;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] ser;

  logic       dv0, pe0, fe0, bk0, bu0;
  logic [7:0] by0;
  logic       dv1, pe1, fe1, bk1, bu1;
  logic [6:0] by1;
  logic       dv2, pe2, fe2, bk2, bu2;
  logic [7:0] by2;

  int checks   = 0;
  int failures = 0;
  int dv2_cnt  = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  vec_t vecs[14];

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_SERIAL(ser[0]), .o_DV(dv0), .o_BYTE(by0),
    .o_PARITY_ERR(pe0), .o_FRAME_ERR(fe0), .o_BREAK(bk0), .o_BUSY(bu0));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_SERIAL(ser[1]), .o_DV(dv1), .o_BYTE(by1),
    .o_PARITY_ERR(pe1), .o_FRAME_ERR(fe1), .o_BREAK(bk1), .o_BUSY(bu1));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_SERIAL(ser[2]), .o_DV(dv2), .o_BYTE(by2),
    .o_PARITY_ERR(pe2), .o_FRAME_ERR(fe2), .o_BREAK(bk2), .o_BUSY(bu2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int d, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s dut%0d: got %h want %h", name, d, got, want);
    end
  endtask

  task automatic push(input int d, input logic [8:0] b, input logic pe, input logic fe, input logic bk);
    exp_t e;
    e.byte_v = b; e.perr = pe; e.ferr = fe; e.brk = bk;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Scoreboard pop on every o_DV
  task automatic mon(input int d, input logic [8:0] b, input logic pe, input logic fe,
                     input logic bk, input logic bu);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (d)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL unexpected_dv dut%0d: got byte %h want no strobe", d, b);
    end else begin
      chk("byte", d, b, e.byte_v);
      chk("parity_err", d, 9'(pe), 9'(e.perr));
      chk("frame_err", d, 9'(fe), 9'(e.ferr));
      chk("break", d, 9'(bk), 9'(e.brk));
      chk("busy_at_dv", d, 9'(bu), 9'd0);
    end
  endtask

  always @(negedge clk) begin
    if (dv0) mon(0, {1'b0, by0}, pe0, fe0, bk0, bu0);
    if (dv1) mon(1, {2'b0, by1}, pe1, fe1, bk1, bu1);
    if (dv2) begin
      dv2_cnt++;
      mon(2, {1'b0, by2}, pe2, fe2, bk2, bu2);
    end
  end

  task automatic send_bit(input int d, input logic v, input logic spike);
    for (int c = 0; c < CPB; c++) begin
      ser[d] = (spike && c == 6) ? ~v : v;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                            input logic par_en, input logic par_bit,
                            input logic [1:0] stop, input int nstop, input logic spike);
    send_bit(d, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d, data[i], spike);
    if (par_en) send_bit(d, par_bit, 1'b0);
    for (int i = 0; i < nstop; i++) send_bit(d, stop[i], 1'b0);
    ser[d] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit saw_busy;
    int dv_before;

    vecs[0]  = '{0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, 8, 1'b0, 1'b0, 2'b11, 1, 9'h000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h0FF, 8, 1'b0, 1'b0, 2'b11, 1, 9'h0FF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 9'h03C, 8, 1'b0, 1'b0, 2'b00, 1, 9'h03C, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{0, 9'h000, 8, 1'b0, 1'b0, 2'b00, 1, 9'h000, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1, 9'h041, 7, 1'b1, 1'b1, 2'b11, 1, 9'h041, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h041, 7, 1'b1, 1'b0, 2'b11, 1, 9'h041, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1, 9'h007, 7, 1'b1, 1'b1, 2'b11, 1, 9'h007, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1, 9'h007, 7, 1'b1, 1'b0, 2'b11, 1, 9'h007, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1, 9'h000, 7, 1'b1, 1'b0, 2'b00, 1, 9'h000, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1, 9'h000, 7, 1'b1, 1'b1, 2'b00, 1, 9'h000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{2, 9'h05A, 8, 1'b0, 1'b0, 2'b01, 2, 9'h05A, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{2, 9'h0C3, 8, 1'b0, 1'b0, 2'b10, 2, 9'h0C3, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{2, 9'h081, 8, 1'b0, 1'b0, 2'b11, 2, 9'h081, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    ser   = 3'b111;
    repeat (2) @(negedge clk);
    chk("reset_dv", 0, 9'(dv0), 9'd0);
    chk("reset_byte", 0, {1'b0, by0}, 9'd0);
    chk("reset_busy", 0, 9'(bu0), 9'd0);
    chk("reset_flags", 1, {6'd0, pe1, fe1, bk1}, 9'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);

    for (int i = 0; i < 14; i++) begin
      push(vecs[i].d, vecs[i].ebyte, vecs[i].eperr, vecs[i].eferr, vecs[i].ebrk);
      send_frame(vecs[i].d, vecs[i].data, vecs[i].nbits, vecs[i].par_en, vecs[i].par_bit,
                 vecs[i].stop, vecs[i].nstop, 1'b0);
      idle(3 * CPB);
    end

    // Short low glitch: START must abort without a strobe
    ser[0] = 1'b0;
    idle(4);
    ser[0] = 1'b1;
    saw_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bu0) saw_busy = 1'b1;
    end
    chk("glitch_busy_seen", 0, 9'(saw_busy), 9'd1);
    chk("glitch_busy_clear", 0, 9'(bu0), 9'd0);
    @(posedge clk); #1;
    idle(2 * CPB);

    // Line held low for 20 bit times on 8N2: one break word only
    dv_before = dv2_cnt;
    push(2, 9'h000, 1'b0, 1'b1, 1'b1);
    ser[2] = 1'b0;
    idle(20 * CPB);
    ser[2] = 1'b1;
    idle(3 * CPB);
    chk("break_dv_count", 2, 9'(dv2_cnt - dv_before), 9'd1);

    // Back-to-back frames with one-cycle spikes inside data bits
    push(0, 9'h012, 1'b0, 1'b0, 1'b0);
    push(0, 9'h034, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h012, 8, 1'b0, 1'b0, 2'b11, 1, 1'b1);
    send_frame(0, 9'h034, 8, 1'b0, 1'b0, 2'b11, 1, 1'b1);
    idle(3 * CPB);

    // Reset in the middle of the data bits of 0x55
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    rst_n  = 1'b0;
    ser[0] = 1'b1;
    @(negedge clk);
    chk("midrst_byte", 0, {1'b0, by0}, 9'd0);
    chk("midrst_busy", 0, 9'(bu0), 9'd0);
    chk("midrst_dv", 0, 9'(dv0), 9'd0);
    chk("midrst_flags", 0, {6'd0, pe0, fe0, bk0}, 9'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(40);
    push(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    idle(6 * CPB);

    chk("pending_dut0", 0, 9'(q0.size()), 9'd0);
    chk("pending_dut1", 1, 9'(q1.size()), 9'd0);
    chk("pending_dut2", 2, 9'(q2.size()), 9'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
